commit_ctrl: RTL
================

// Module: commit_ctrl
// PURPOSE
//  Retire stage directly downstream of the ROB; up to two instructions per cycle, strictly in order.
//  - Inputs: the ROB's two oldest entries.
//  - Drives back to ROB: commit_req[1:0].
//  - Drives forward: ARF writes, one store per cycle to the store buffer, and the pipeline-wide flush/redirect.
//  - Serialises exceptions, branch mispredicts, CSR/TLB/ertn/idle instructions.
// PARAMETERS
//  FLUSH_CYCLES  2   cycles in S_FLUSH after the flush pulse during which nothing commits (min 1)
//  AREG_W        5   architectural register index width
// PORTS
//  clk           in   1      clock
//  rst_n         in   1      synchronous, active-low reset
//  c_valid_i     in   2      ROB slot[i] holds a completed instruction (slot0 = oldest)
//  pc_i          in   2x32   instruction PC per slot
//  w_reg_i       in   2      slot writes a GPR
//  areg_i        in   2xAREG_W  destination architectural register
//  w_data_i      in   2x32   result data
//  w_mem_i       in   2      slot is a store
//  st_addr_i     in   2x32   store address
//  st_data_i     in   2x32   store data
//  exc_i         in   2      slot raised an exception (fetch/decode/execute)
//  mispred_i     in   2      branch misprediction
//  br_target_i   in   2x32   correct branch target
//  serial_i      in   2      CSR/TLB/cacop/ibar/ertn instruction; must retire alone
//  ertn_i        in   2      slot is ertn
//  idle_i        in   2      slot is idle
//  eentry_i      in   32     exception entry from CSR
//  era_i         in   32     return address from CSR
//  int_i         in   1      pending interrupt (wakes idle)
//  st_ready_i    in   1      store buffer accepts
//  commit_req_o  out  2      retire slot[i] this cycle (combinational, to ROB)
//  arf_we_o      out  2      ARF write enable
//  arf_waddr_o   out  2xAREG_W  ARF write address
//  arf_wdata_o   out  2x32   ARF write data
//  st_valid_o    out  1      store request (combinational)
//  st_addr_o     out  32     store address
//  st_data_o     out  32     store data
//  flush_o       out  1      registered one-cycle flush pulse
//  redirect_pc_o out  32     valid with flush_o
// BEHAVIOUR
//  - Reset: all outputs 0; state S_NORMAL; flush counter 0.
//  - States: S_NORMAL, S_FLUSH, S_IDLE.
//    - S_FLUSH and S_IDLE: commit_req=0, st_valid=0.
//  - Slot0 in S_NORMAL, commit0 = c_valid_i[0] & (!w_mem_i[0] | exc_i[0] | st_ready_i).
//    - st_valid_o = c_valid_i[0] & w_mem_i[0] & !exc_i[0]; valid may drop only after acceptance or flush.
//  - Slot1: commit1 = commit0 & c_valid_i[1], and no event on either slot.
//    - Slot0 must have none of: exc, mispred, serial, idle, store.
//    - Slot1 must have none of: exc, mispred, serial, idle, w_mem.
//    - Otherwise slot1 waits and becomes slot0 next cycle. Only one flush source per cycle, always slot0.
//  - ARF write: arf_we[i] = commit[i] & w_reg[i] & !exc[i] & (areg[i] != 0).
//  - Flush events on committed slot0 (priority order):
//    - exc: redirect = eentry_i, no ARF/store side effect.
//    - ertn: redirect = era_i.
//    - mispred: redirect = br_target.
//    - serial: redirect = pc+4.
//    - idle: go to S_IDLE, no flush.
//  - Flush timing: flush_o and redirect_pc_o are registered, asserted the cycle after the commit for exactly one cycle.
//    - State moves to S_FLUSH for FLUSH_CYCLES cycles, then back to S_NORMAL.
//    - ROB contents are invalid throughout, since it flushes on flush_o.
//  - S_IDLE: exits on int_i with flush_o, redirect = pc_idle+4; timing identical to other flushes.
//  - Reset mid-S_FLUSH/S_IDLE: returns to S_NORMAL, pending flush is dropped.
//  - Width rule: pc+4 wraps modulo 2^32.
// CONFIGURATION
//  COMMIT_PERF_CNT_EN defined:
//    - Adds outputs perf_commit_o[63:0] (+= popcount(commit_req) each cycle) and perf_flush_o[31:0] (+1 per flush_o).
//    - Both reset to 0 and wrap.
//  COMMIT_PERF_CNT_EN undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  - Shared package (a_defines): commit_state_e; FLUSH_CAUSE enum (EXC/ERTN/MISPRED/SERIAL/IDLE); PC_STEP=4.
//  - One sub-module, commit_flush_gen: registered flush pulse, redirect mux, FLUSH_CYCLES counter.
// TESTING
//  1. Two plain ALU ops, c_valid=2'b11, areg 3/4 -> commit_req=11, arf_we=11, no flush.
//  2. Slot0 store, st_ready=0 for 3 cycles then 1 -> commit_req=00 for 3 cycles, then 01. Slot1 ALU commits the following cycle.
//  3. Slot0 mispred, br_target=0x1c000100, slot1 valid -> commit_req=01; next cycle flush_o=1, redirect=0x1c000100; commit_req=0 for FLUSH_CYCLES cycles.
//  4. Slot0 exc, eentry=0x1c008000, w_reg=1 -> arf_we=0, commit_req=01, flush redirect=0x1c008000.
//  5. Slot0 ALU, slot1 csr (serial) -> only slot0 commits. Next cycle csr commits alone, flush redirect=pc+4.
//  6. idle at pc 0x1c000020, int_i asserted 5 cycles later -> no commits meanwhile, then flush_o with redirect=0x1c000024. Reset asserted during S_IDLE -> S_NORMAL, flush_o=0.

Source files
------------

// File: rtl/commit_ctrl_pkg.sv
// Shared types for the retire stage: FSM states, flush causes and the PC step.
// Imported by commit_ctrl and commit_flush_gen.
package commit_ctrl_pkg;

    typedef enum logic [1:0] {
        S_NORMAL = 2'd0,
        S_FLUSH  = 2'd1,
        S_IDLE   = 2'd2
    } commit_state_e;

    typedef enum logic [2:0] {
        CAUSE_EXC     = 3'd0,
        CAUSE_ERTN    = 3'd1,
        CAUSE_MISPRED = 3'd2,
        CAUSE_SERIAL  = 3'd3,
        CAUSE_IDLE    = 3'd4
    } flush_cause_e;

    localparam logic [31:0] PC_STEP = 32'd4;

    // Sequential PC; wraps modulo 2^32 by construction.
    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/commit_ctrl_if.sv
// Bundle between ROB head, retire stage, ARF, store buffer and the pipeline flush network.
// master = retire stage, slave = surrounding pipeline.
interface commit_ctrl_if #(
    parameter int AREG_W = 5
);
    logic [1:0]             c_valid;
    logic [1:0][31:0]       pc;
    logic [1:0]             w_reg;
    logic [1:0][AREG_W-1:0] areg;
    logic [1:0][31:0]       w_data;
    logic [1:0]             w_mem;
    logic [1:0][31:0]       st_addr;
    logic [1:0][31:0]       st_data;
    logic [1:0]             exc;
    logic [1:0]             mispred;
    logic [1:0][31:0]       br_target;
    logic [1:0]             serial;
    logic [1:0]             ertn;
    logic [1:0]             idle;
    logic [31:0]            eentry;
    logic [31:0]            era;
    logic                   irq;
    logic                   st_ready;

    logic [1:0]             commit_req;
    logic [1:0]             arf_we;
    logic [1:0][AREG_W-1:0] arf_waddr;
    logic [1:0][31:0]       arf_wdata;
    logic                   sb_valid;
    logic [31:0]            sb_addr;
    logic [31:0]            sb_data;
    logic                   flush;
    logic [31:0]            redirect_pc;

    modport master (
        input  c_valid, pc, w_reg, areg, w_data, w_mem, st_addr, st_data,
               exc, mispred, br_target, serial, ertn, idle, eentry, era, irq, st_ready,
        output commit_req, arf_we, arf_waddr, arf_wdata, sb_valid, sb_addr, sb_data,
               flush, redirect_pc
    );

    modport slave (
        output c_valid, pc, w_reg, areg, w_data, w_mem, st_addr, st_data,
               exc, mispred, br_target, serial, ertn, idle, eentry, era, irq, st_ready,
        input  commit_req, arf_we, arf_waddr, arf_wdata, sb_valid, sb_addr, sb_data,
               flush, redirect_pc
    );

endinterface

// File: rtl/commit_ctrl_flush_gen.sv
// Registered flush pulse with redirect selection and the post-flush hold down-counter.
// hold_done is high once the hold window has run out.
module commit_flush_gen
    import commit_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_req,
    input  flush_cause_e cause,
    input  logic [31:0]  pc0,
    input  logic [31:0]  br_target0,
    input  logic [31:0]  eentry,
    input  logic [31:0]  era,
    input  logic [31:0]  pc_idle,
    output logic         flush,
    output logic [31:0]  redirect_pc,
    output logic         hold_done
);

    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    // The pulse cycle itself is the first hold cycle, so load one less.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    logic [CNT_W-1:0] hold_cnt;
    logic [31:0]      redirect_nxt;

    always_comb begin
        redirect_nxt = '0;
        unique case (cause)
            CAUSE_EXC:     redirect_nxt = eentry;
            CAUSE_ERTN:    redirect_nxt = era;
            CAUSE_MISPRED: redirect_nxt = br_target0;
            CAUSE_SERIAL:  redirect_nxt = next_pc(pc0);
            CAUSE_IDLE:    redirect_nxt = next_pc(pc_idle);
            default:       redirect_nxt = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flush       <= 1'b0;
            redirect_pc <= '0;
            hold_cnt    <= '0;
        end else begin
            flush       <= flush_req;
            redirect_pc <= flush_req ? redirect_nxt : '0;
            if (flush_req) begin
                hold_cnt <= CNT_LOAD;
            end else if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - 1'b1;
            end
        end
    end

    assign hold_done = (hold_cnt == '0);

endmodule

// File: rtl/commit_ctrl.sv
// In-order two-wide retire stage: commit requests to the ROB, ARF/store writes, flush/redirect.
// Defining COMMIT_PERF_CNT_EN adds the perf_commit_o / perf_flush_o counters.
//
// state    | meaning
// S_NORMAL | retiring from the ROB head
// S_FLUSH  | flush issued, commits held for FLUSH_CYCLES cycles
// S_IDLE   | idle retired, waiting for an interrupt
module commit_ctrl
    import commit_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int AREG_W       = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    commit_ctrl_if.master cif
`ifdef COMMIT_PERF_CNT_EN
    ,
    output logic [63:0]   perf_commit_o,
    output logic [31:0]   perf_flush_o
`endif
);

    localparam logic [AREG_W-1:0] AREG_ZERO = '0;

    commit_state_e state, state_nxt;
    flush_cause_e  cause;
    logic          normal;
    logic          ev0, ev1;
    logic          commit0, commit1;
    logic [1:0]    commit_vec;
    logic          flush_req;
    logic          idle_enter;
    logic          hold_done;
    logic [31:0]   pc_idle;
    logic          unused_hi;

    always_comb begin
        flush_req  = 1'b0;
        idle_enter = 1'b0;
        cause      = CAUSE_EXC;
        state_nxt  = state;

        normal  = rst_n && (state == S_NORMAL);
        ev0     = cif.exc[0] | cif.mispred[0] | cif.serial[0] | cif.ertn[0] | cif.idle[0] | cif.w_mem[0];
        ev1     = cif.exc[1] | cif.mispred[1] | cif.serial[1] | cif.ertn[1] | cif.idle[1] | cif.w_mem[1];
        // A faulting store retires without waiting for the store buffer.
        commit0 = normal && cif.c_valid[0] && (!cif.w_mem[0] || cif.exc[0] || cif.st_ready);
        commit1 = commit0 && cif.c_valid[1] && !ev0 && !ev1;

        if (commit0) begin
            if (cif.exc[0]) begin
                flush_req = 1'b1;
                cause     = CAUSE_EXC;
            end else if (cif.ertn[0]) begin
                flush_req = 1'b1;
                cause     = CAUSE_ERTN;
            end else if (cif.mispred[0]) begin
                flush_req = 1'b1;
                cause     = CAUSE_MISPRED;
            end else if (cif.serial[0]) begin
                flush_req = 1'b1;
                cause     = CAUSE_SERIAL;
            end else if (cif.idle[0]) begin
                idle_enter = 1'b1;
            end
        end

        if (rst_n && (state == S_IDLE) && cif.irq) begin
            flush_req = 1'b1;
            cause     = CAUSE_IDLE;
        end

        case (state)
            S_NORMAL: begin
                if (flush_req) state_nxt = S_FLUSH;
                else if (idle_enter) state_nxt = S_IDLE;
            end
            S_FLUSH:  if (hold_done) state_nxt = S_NORMAL;
            S_IDLE:   if (flush_req) state_nxt = S_FLUSH;
            default:  state_nxt = S_NORMAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_NORMAL;
            pc_idle <= '0;
        end else begin
            state <= state_nxt;
            if (idle_enter) pc_idle <= cif.pc[0];
        end
    end

    always_comb begin
        commit_vec     = {commit1, commit0};
        cif.commit_req = commit_vec;
        cif.arf_we     = '0;
        cif.arf_waddr  = '0;
        cif.arf_wdata  = '0;
        for (int i = 0; i < 2; i++) begin
            if (commit_vec[i] && cif.w_reg[i] && !cif.exc[i] && (cif.areg[i] != AREG_ZERO)) begin
                cif.arf_we[i]    = 1'b1;
                cif.arf_waddr[i] = cif.areg[i];
                cif.arf_wdata[i] = cif.w_data[i];
            end
        end
        cif.sb_valid = normal && cif.c_valid[0] && cif.w_mem[0] && !cif.exc[0];
        cif.sb_addr  = cif.sb_valid ? cif.st_addr[0] : '0;
        cif.sb_data  = cif.sb_valid ? cif.st_data[0] : '0;
    end

    // Slot1 fields that only matter once the entry moves into slot0.
    assign unused_hi = ^{cif.pc[1], cif.br_target[1], cif.st_addr[1], cif.st_data[1]};

    commit_flush_gen #(
        .FLUSH_CYCLES(FLUSH_CYCLES)
    ) u_flush_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_req   (flush_req),
        .cause       (cause),
        .pc0         (cif.pc[0]),
        .br_target0  (cif.br_target[0]),
        .eentry      (cif.eentry),
        .era         (cif.era),
        .pc_idle     (pc_idle),
        .flush       (cif.flush),
        .redirect_pc (cif.redirect_pc),
        .hold_done   (hold_done)
    );

`ifdef COMMIT_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_commit_o <= '0;
            perf_flush_o  <= '0;
        end else begin
            perf_commit_o <= perf_commit_o + 64'(commit0) + 64'(commit1);
            perf_flush_o  <= perf_flush_o + 32'(cif.flush);
        end
    end
`endif

endmodule
